// File: rtl/prog_loader.sv
// Byte-stream program loader: receives a word count, little-endian instruction
// words and an XOR checksum, writes them to instruction memory and releases the CPU.
module prog_loader #(
  parameter int          DEPTH = 64,
  parameter int          AW    = 6,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_byte,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_rst,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CHK,
    S_FILL,
    S_RUN,
    S_ERR
  } state_e;

  // One extra bit so a count equal to DEPTH is representable.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  state_e        state_q, state_d;
  logic [AW:0]   n_q, n_d;
  logic [AW:0]   idx_q, idx_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [23:0]   word_q, word_d;
  logic [7:0]    csum_q, csum_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;

  logic accept;
  logic fill_active;

  assign in_ready    = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
  assign accept      = in_valid && in_ready;
  assign fill_active = (state_q == S_FILL);

  // NOTE: every _d gets its hold value before the case statement, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (start) begin
      // A start pulse from any state restarts the header; partial progress is dropped.
      state_d = S_HDR;
      idx_d   = '0;
      bcnt_d  = '0;
      word_d  = '0;
      csum_d  = '0;
    end else begin
      unique case (state_q)
        S_HDR: begin
          if (accept) begin
            if (in_byte == 8'd0 || int'(in_byte) > DEPTH) begin
              state_d = S_ERR;
            end else begin
              n_d     = (AW+1)'(in_byte);
              idx_d   = '0;
              bcnt_d  = '0;
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            csum_d = csum_q ^ in_byte;
            bcnt_d = bcnt_q + 2'd1;
            word_d = {in_byte, word_q[23:8]};
            if (bcnt_q == 2'd3) begin
              we_d    = 1'b1;
              addr_d  = idx_q[AW-1:0];
              wdata_d = {in_byte, word_q};
              idx_d   = idx_q + ONE_W;
              if (idx_q + ONE_W == n_q) state_d = S_CHK;
            end
          end
        end
        S_CHK: begin
          if (accept) begin
            if (in_byte != csum_q)  state_d = S_ERR;
            else if (n_q < DEPTH_W) state_d = S_FILL;
            else                    state_d = S_RUN;
          end
        end
        S_FILL: begin
          idx_d = idx_q + ONE_W;
          if (idx_q == DEPTH_W - ONE_W) state_d = S_RUN;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments only, and every counter,
  // the checksum and the pending write are cleared by the asynchronous reset so a
  // reset mid-load can never emit a stale imem write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Data writes come from the registered write port; NOP fill is driven straight
  // from the FILL state and its running index.
  assign imem_we    = we_q || fill_active;
  assign imem_addr  = fill_active ? idx_q[AW-1:0] : addr_q;
  assign imem_wdata = fill_active ? NOP : wdata_q;

  assign cpu_rst = (state_q != S_RUN);
  assign done    = (state_q == S_RUN);
  assign err     = (state_q == S_ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected imem writes are queued by the stimulus
// and a monitor pops and compares them whenever imem_we is seen.
module tb_prog_loader;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_byte;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;

  prog_loader #(.DEPTH(DEPTH), .AW(AW), .NOP(32'h0000_0013)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] words[DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every observed write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst === 1'b1 && imem_we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h expected no write", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data) begin
          errors++;
          $display("FAIL imem_write: got addr=%0d data=%h expected addr=%0d data=%h",
                   imem_addr, imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Present one byte and hold it until a rising edge with in_ready=1 takes it.
  task automatic send_byte(input logic [7:0] b, input bit bubble);
    int waited = 0;
    if (bubble) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) check("handshake_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  function automatic logic [7:0] xor_sum(input int n);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < n; i++)
      s = s ^ words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
    return s;
  endfunction

  // Sends header, data and checksum; assumes the loader is already in HDR.
  task automatic load(input int n, input logic [7:0] chk, input bit bubble, input bit good);
    for (int i = 0; i < n; i++) exp_q.push_back('{addr: AW'(i), data: words[i]});
    if (good)
      for (int a = n; a < DEPTH; a++) exp_q.push_back('{addr: AW'(a), data: 32'h0000_0013});
    send_byte(8'(n), bubble);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) send_byte(words[i][8*j +: 8], bubble);
      @(negedge clk);
      check("we_cycle_after_word", {31'd0, imem_we}, 32'd1);
    end
    send_byte(chk, bubble);
  endtask

  // Counts negedges from the checksum handshake until done rises.
  task automatic wait_done(input int exp_cycles);
    int cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (done !== 1'b1 && cnt < 200);
    check("cycles_to_run", cnt, exp_cycles);
    check("run_done", {31'd0, done}, 32'd1);
    check("run_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("run_queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    #2;
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_imem_we", {31'd0, imem_we}, 32'd0);
    check("rst_imem_addr", {26'd0, imem_addr}, 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ignores_valid", {31'd0, in_ready}, 32'd0);

    // Reference stream: two words, XOR of the eight data bytes is 0x11.
    words[0] = 32'h00A0_0093;
    words[1] = 32'h0030_0113;
    pulse_start();
    load(2, 8'h11, 1'b0, 1'b1);
    wait_done(63);

    // Start while running drops straight back to HDR.
    pulse_start();
    @(negedge clk);
    check("restart_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("restart_done", {31'd0, done}, 32'd0);
    check("restart_in_ready", {31'd0, in_ready}, 32'd1);

    // Same stream with a bubble before every byte.
    load(2, 8'h11, 1'b1, 1'b1);
    wait_done(63);

    // Wrong checksum: data words still written, no fill, error raised.
    pulse_start();
    load(2, 8'h10, 1'b0, 1'b0);
    @(negedge clk);
    check("chk_fault_err", {31'd0, err}, 32'd1);
    check("chk_fault_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    repeat (70) @(negedge clk);
    check("chk_fault_err_held", {31'd0, err}, 32'd1);
    check("chk_fault_no_fill", exp_q.size(), 0);

    // Header faults: N=0 and N=65.
    pulse_start();
    @(negedge clk);
    check("start_clears_err", {31'd0, err}, 32'd0);
    send_byte(8'd0, 1'b0);
    @(negedge clk);
    check("hdr0_err", {31'd0, err}, 32'd1);
    check("hdr0_in_ready", {31'd0, in_ready}, 32'd0);
    pulse_start();
    send_byte(8'd65, 1'b0);
    @(negedge clk);
    check("hdr65_err", {31'd0, err}, 32'd1);
    check("hdr65_cpu_rst", {31'd0, cpu_rst}, 32'd1);

    // Full-depth load: no fill, RUN immediately after the checksum.
    for (int i = 0; i < DEPTH; i++)
      words[i] = {8'(i), 8'(i * 3), 8'hA5, 8'(255 - i)};
    pulse_start();
    load(DEPTH, xor_sum(DEPTH), 1'b0, 1'b1);
    wait_done(1);

    // Restart mid-DATA discards the partial word.
    words[0] = 32'h00A0_0093;
    words[1] = 32'h0030_0113;
    pulse_start();
    send_byte(8'd2, 1'b0);
    for (int j = 0; j < 3; j++) send_byte(words[0][8*j +: 8], 1'b0);
    pulse_start();
    @(negedge clk);
    check("midload_restart_in_ready", {31'd0, in_ready}, 32'd1);
    load(2, 8'h11, 1'b0, 1'b1);
    wait_done(63);

    // Asynchronous reset after five data bytes.
    pulse_start();
    exp_q.push_back('{addr: AW'(0), data: words[0]});
    send_byte(8'd2, 1'b0);
    for (int j = 0; j < 4; j++) send_byte(words[0][8*j +: 8], 1'b0);
    send_byte(words[1][7:0], 1'b0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("async_rst_imem_we", {31'd0, imem_we}, 32'd0);
    check("async_rst_imem_addr", {26'd0, imem_addr}, 32'd0);
    check("async_rst_imem_wdata", imem_wdata, 32'd0);
    check("async_rst_word0_written", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    pulse_start();
    load(2, 8'h11, 1'b0, 1'b1);
    wait_done(63);

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
